// File: rtl/orion_adc_status.sv
// ============================================================================
// Module   : orion_adc_status
// Purpose  : Periodic ADC snapshot with a peak-detect restart handshake,
//            framed out over a valid/ready byte stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module orion_adc_status #(
  parameter int INTERVAL    = 30720,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] AIN1,
  input  logic [11:0] AIN2,
  input  logic [11:0] AIN3,
  input  logic [11:0] AIN4,
  input  logic [11:0] AIN5,
  input  logic [11:0] AIN6,
  output logic        pk_detect_reset,
  input  logic        pk_detect_ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  input  logic        err_clear,
  output logic        ack_timeout_err,
  output logic        overrun_err
);

  localparam int              c_TW       = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [c_TW-1:0] c_TMR_LAST = c_TW'(INTERVAL - 1);
  localparam logic [7:0]      c_ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0]      c_IDX_LAST = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_REQ  = 3'd2,
    S_REL  = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_TW-1:0]   r_timer;
  logic              r_pending;
  logic [7:0]        r_seq;
  logic [7:0]        r_ack_cnt;
  logic [3:0]        r_idx;
  logic [11:0]       r_snap [6];
  logic              r_pk;
  logic              r_tx_valid;
  logic              r_tx_last;
  logic [7:0]        r_tx_data;
  logic              r_ack_err;
  logic              r_ovr_err;

  logic              w_tick;
  logic              w_ack_to;
  logic              w_overrun;
  logic [3:0]        w_next_idx;
  logic [7:0]        w_csum;
  logic [7:0]        w_frame [16];

  assign w_tick     = enable && (r_timer == c_TMR_LAST);
  assign w_overrun  = w_tick && (r_state != S_IDLE) && r_pending;
  assign w_ack_to   = (r_ack_cnt == c_ACK_LAST) &&
                      (((r_state == S_REQ) && !pk_detect_ack) ||
                       ((r_state == S_REL) &&  pk_detect_ack));
  assign w_next_idx = r_idx + 4'd1;

  // Frame image built from the snapshot; byte 14 is the XOR of bytes 0..13.
  always_comb begin
    w_frame[0] = 8'hA5;
    w_frame[1] = r_seq;
    for (int i = 0; i < 6; i++) begin
      w_frame[2 + 2*i] = {4'h0, r_snap[i][11:8]};
      w_frame[3 + 2*i] = r_snap[i][7:0];
    end
    w_csum = 8'h00;
    for (int i = 0; i < 14; i++) begin
      w_csum = w_csum ^ w_frame[i];
    end
    w_frame[14] = w_csum;
    w_frame[15] = 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_ack_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      if (!enable || w_tick) r_timer <= '0;
      else                   r_timer <= r_timer + 1'b1;

      // A tick that coincides with leaving IDLE is consumed by that exit.
      if (!enable)                                    r_pending <= 1'b0;
      else if (w_tick && (r_state != S_IDLE))         r_pending <= 1'b1;
      else if ((r_state == S_IDLE) && r_pending && !w_tick) r_pending <= 1'b0;

      if (w_ack_to)       r_ack_err <= 1'b1;
      else if (err_clear) r_ack_err <= 1'b0;

      if (w_overrun)      r_ovr_err <= 1'b1;
      else if (err_clear) r_ovr_err <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_seq      <= 8'h00;
      r_ack_cnt  <= 8'h00;
      r_idx      <= 4'd0;
      r_pk       <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_tx_data  <= 8'h00;
      for (int i = 0; i < 6; i++) r_snap[i] <= 12'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && (w_tick || r_pending)) r_state <= S_SNAP;
        end
        S_SNAP: begin
          r_snap[0] <= AIN1;
          r_snap[1] <= AIN2;
          r_snap[2] <= AIN3;
          r_snap[3] <= AIN4;
          r_snap[4] <= AIN5;
          r_snap[5] <= AIN6;
          r_pk      <= 1'b1;
          r_ack_cnt <= 8'h00;
          r_state   <= S_REQ;
        end
        S_REQ, S_REL: begin
          if ((r_state == S_REQ) && pk_detect_ack) begin
            r_pk      <= 1'b0;
            r_ack_cnt <= 8'h00;
            r_state   <= S_REL;
          end else if (((r_state == S_REL) && !pk_detect_ack) || w_ack_to) begin
            r_pk       <= 1'b0;
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
            r_tx_data  <= w_frame[0];
            r_idx      <= 4'd0;
            r_state    <= S_SEND;
          end else begin
            r_ack_cnt <= r_ack_cnt + 8'd1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_idx == c_IDX_LAST) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_seq      <= r_seq + 8'd1;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_frame[w_next_idx];
              r_tx_last <= (w_next_idx == c_IDX_LAST);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pk_detect_reset = r_pk;
  assign tx_valid        = r_tx_valid;
  assign tx_last         = r_tx_last;
  assign tx_data         = r_tx_data;
  assign ack_timeout_err = r_ack_err;
  assign overrun_err     = r_ovr_err;

endmodule

`default_nettype wire

// File: tb/tb_orion_adc_status.sv
// ============================================================================
// Module   : tb_orion_adc_status
// Purpose  : Scoreboard bench for orion_adc_status (INTERVAL=100, ACK_TIMEOUT=16).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_orion_adc_status;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [11:0] ain [6];
  logic        pk_detect_reset;
  logic        pk_detect_ack = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        err_clear;
  logic        ack_timeout_err;
  logic        overrun_err;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          frame_bytes = 0;
  int          frames_done = 0;
  int          pk_cnt = 0;
  logic [7:0]  m_seq = 8'h00;
  logic        ack_en = 1'b1;
  logic [2:0]  ack_sh = 3'b000;

  // First frame, worked by hand; the last byte is the XOR of the other 14.
  logic [7:0]  c_frame1 [15] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89,
                                 8'h0A, 8'hBC, 8'h0D, 8'hEF, 8'h00, 8'hFF, 8'hF0};

  orion_adc_status #(.INTERVAL(100), .ACK_TIMEOUT(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .AIN1           (ain[0]),
    .AIN2           (ain[1]),
    .AIN3           (ain[2]),
    .AIN4           (ain[3]),
    .AIN5           (ain[4]),
    .AIN6           (ain[5]),
    .pk_detect_reset(pk_detect_reset),
    .pk_detect_ack  (pk_detect_ack),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_last        (tx_last),
    .err_clear      (err_clear),
    .ack_timeout_err(ack_timeout_err),
    .overrun_err    (overrun_err)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scanner model: ack follows pk_detect_reset three clocks later.
  initial forever begin
    logic s;
    @(posedge clock);
    s = pk_detect_reset;
    #1;
    ack_sh = {ack_sh[1:0], s};
    pk_detect_ack = ack_en & ack_sh[2];
  end

  // Monitor: pops one expected byte per handshake.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (!reset_n) begin
      q.delete();
      frame_bytes = 0;
    end else begin
      if (pk_detect_reset) pk_cnt++;
      if (tx_valid && tx_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got 0x%0h, no byte expected", tx_data);
        end else begin
          e = q.pop_front();
          check($sformatf("tx_data[%0d]", frame_bytes), {24'h0, tx_data}, {24'h0, e.d});
          check($sformatf("tx_last[%0d]", frame_bytes), {31'h0, tx_last}, {31'h0, e.l});
        end
        frame_bytes++;
        if (tx_last) begin
          frame_bytes = 0;
          frames_done++;
        end
      end
    end
  end

  task automatic tick1();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_frame();
    logic [7:0] b [15];
    logic [7:0] cs;
    exp_t       e;
    b[0] = 8'hA5;
    b[1] = m_seq;
    for (int i = 0; i < 6; i++) begin
      b[2 + 2*i] = {4'h0, ain[i][11:8]};
      b[3 + 2*i] = ain[i][7:0];
    end
    cs = 8'h00;
    for (int i = 0; i < 14; i++) cs = cs ^ b[i];
    b[14] = cs;
    for (int i = 0; i < 15; i++) begin
      e.d = b[i];
      e.l = (i == 14);
      q.push_back(e);
    end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic wait_drained(input int bound);
    int n = 0;
    while ((q.size() != 0 || tx_valid) && n < bound) begin
      tick1();
      n++;
    end
    check("drain_in_time", {31'h0, (n < bound)}, 32'h1);
  endtask

  task automatic wait_bytes(input int nb, input int bound);
    int n = 0;
    while (frame_bytes != nb && n < bound) begin
      tick1();
      n++;
    end
    check("reach_byte", frame_bytes, nb);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick1();
    err_clear = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [7:0] held;
    logic       stable;
    int         n, f0, act, p0;

    reset_n = 1'b0; enable = 1'b0; tx_ready = 1'b1; err_clear = 1'b0;
    for (int i = 0; i < 6; i++) ain[i] = 12'h000;
    repeat (3) tick1();
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_last", {31'h0, tx_last}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_pk", {31'h0, pk_detect_reset}, 32'h0);
    check("rst_ack_err", {31'h0, ack_timeout_err}, 32'h0);
    check("rst_ovr_err", {31'h0, overrun_err}, 32'h0);
    reset_n = 1'b1;
    tick1();

    // Nominal frame against the hand-worked table.
    ain = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h0FF};
    for (int i = 0; i < 15; i++) begin
      e.d = c_frame1[i];
      e.l = (i == 14);
      q.push_back(e);
    end
    m_seq = 8'h01;
    enable = 1'b1;
    wait_drained(300);
    enable = 1'b0;
    check("nominal_ack_err", {31'h0, ack_timeout_err}, 32'h0);
    check("nominal_ovr_err", {31'h0, overrun_err}, 32'h0);

    // No acknowledge at all: timeout path.
    ack_en = 1'b0;
    ain = '{12'hFFF, 12'h000, 12'h800, 12'h0F0, 12'h00F, 12'h5A5};
    expect_frame();
    p0 = pk_cnt;
    enable = 1'b1;
    wait_drained(300);
    enable = 1'b0;
    check("pk_high_clocks", pk_cnt - p0, 16);
    check("ack_err_set", {31'h0, ack_timeout_err}, 32'h1);
    pulse_clear();
    check("ack_err_cleared", {31'h0, ack_timeout_err}, 32'h0);
    ack_en = 1'b1;

    // Consumer stall across two ticks: pending then overrun.
    ain = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'hFED, 12'h001};
    expect_frame();
    expect_frame();
    enable = 1'b1;
    wait_bytes(5, 400);
    tx_ready = 1'b0;
    held = tx_data;
    stable = 1'b1;
    repeat (250) begin
      tick1();
      if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
    end
    check("byte5_stable", {31'h0, stable}, 32'h1);
    check("overrun_set", {31'h0, overrun_err}, 32'h1);
    f0 = frames_done;
    tx_ready = 1'b1;
    n = 0;
    while (frames_done == f0 && n < 100) begin tick1(); n++; end
    n = 0;
    while (!tx_valid && n < 40) begin tick1(); n++; end
    check("pending_restart_fast", {31'h0, (n < 20)}, 32'h1);
    enable = 1'b0;
    wait_drained(200);
    pulse_clear();
    check("overrun_cleared", {31'h0, overrun_err}, 32'h0);

    // Enable dropped mid-frame: frame completes, then silence.
    ain = '{12'h0AA, 12'h155, 12'h2AA, 12'h355, 12'h4AA, 12'h555};
    expect_frame();
    enable = 1'b1;
    wait_bytes(3, 400);
    enable = 1'b0;
    wait_drained(100);
    act = 0;
    repeat (500) begin
      tick1();
      if (pk_detect_reset || tx_valid) act++;
    end
    check("quiet_after_disable", act, 0);

    // Reset during byte 7 discards the frame; next frame restarts at seq 0.
    expect_frame();
    enable = 1'b1;
    wait_bytes(7, 400);
    reset_n = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("async_rst_tx_data", {24'h0, tx_data}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    m_seq = 8'h00;
    @(negedge clock);
    expect_frame();
    wait_drained(300);
    enable = 1'b0;

    // Sequence number wraps after 256 frames.
    reset_n = 1'b0;
    tick1();
    reset_n = 1'b1;
    m_seq = 8'h00;
    @(negedge clock);
    for (int k = 0; k < 257; k++) expect_frame();
    enable = 1'b1;
    wait_drained(27000);
    enable = 1'b0;
    check("wrap_ack_err", {31'h0, ack_timeout_err}, 32'h0);
    check("wrap_ovr_err", {31'h0, overrun_err}, 32'h0);

    repeat (5) tick1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
